// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter: FSM state,
// counter-width helpers and the frame-length clamp.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_GAP_CYCLES = 2;

  // Bit counter must hold WIDTH itself, hence the extra bit.
  function automatic int unsigned len_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // A zero-cycle gap still gets a 1-bit counter so no zero-width vector exists.
  function automatic int unsigned gap_w(input int unsigned gap);
    return (gap > 0) ? $clog2(gap + 1) : 1;
  endfunction

  localparam int unsigned DEF_LEN_W = len_w(DEF_WIDTH);
  localparam int unsigned DEF_GAP_W = gap_w(DEF_GAP_CYCLES);

  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out register. On load it exposes the frame's first bit
// combinationally and keeps the remaining bits left-aligned for shifting.
module piso_shreg
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int LEN_W = len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  output logic             first_bit,
  output logic             head
);

  logic [WIDTH-1:0] sr;

  // NOTE: pure datapath register, left without reset; the FSM never reads it
  // outside a frame that was loaded first.
  always_ff @(posedge clk) begin
    if (load) begin
      sr <= data << (WIDTH - int'(len) + 1);
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  // NOTE: default before the loop keeps this combinational, no latch.
  always_comb begin
    first_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (len == LEN_W'(i + 1)) first_bit = data[i];
    end
  end

  assign head = sr[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sends a parallel frame MSB first on x_out with a
// valid strobe, a last-bit done pulse and a configurable idle gap.
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int   WIDTH      = DEF_WIDTH,
  parameter int   GAP_CYCLES = DEF_GAP_CYCLES,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int  LEN_W      = len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = gap_w(GAP_CYCLES);

  tx_state_e        state;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] len_eff;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             shift;
  logic             first_bit;
  logic             head;

  assign load_ready = (state == IDLE) && rst_n && !abort;
  assign accept     = load_valid && load_ready;
  assign len_eff    = LEN_W'(eff_len(32'(load_len), WIDTH));
  // bit_cnt counts bits still to send after the one currently on x_out.
  assign shift      = (state == SHIFT) && !abort && (bit_cnt != '0);

  piso_shreg #(.WIDTH(WIDTH)) u_piso (
    .clk       (clk),
    .load      (accept),
    .shift     (shift),
    .data      (load_data),
    .len       (len_eff),
    .first_bit (first_bit),
    .head      (head)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_out   <= IDLE_LEVEL;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= SHIFT;
            x_out   <= first_bit;
            x_valid <= 1'b1;
            busy    <= 1'b1;
            done    <= (len_eff == LEN_W'(1));
            bit_cnt <= len_eff - LEN_W'(1);
          end
        end
        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            x_out   <= IDLE_LEVEL;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end else if (bit_cnt == '0) begin
            x_out   <= IDLE_LEVEL;
            x_valid <= 1'b0;
            done    <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            x_out   <= head;
            bit_cnt <= bit_cnt - LEN_W'(1);
            done    <= (bit_cnt == LEN_W'(1));
          end
        end
        GAP: begin
          if (abort || gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          x_out   <= IDLE_LEVEL;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (gap 2 and gap 0) share stimulus and
// are checked every cycle against a queue-based model, plus literal frame checks.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic [3:0] load_len;
  logic       abort;

  logic ready0, x0, v0, b0, d0;
  logic ready1, x1, v1, b1, d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready0),
    .load_data(load_data), .load_len(load_len), .abort(abort),
    .x_out(x0), .x_valid(v0), .busy(b0), .done(d0)
  );

  serial_frame_tx #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready1),
    .load_data(load_data), .load_len(load_len), .abort(abort),
    .x_out(x1), .x_valid(v1), .busy(b1), .done(d1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: each accepted frame becomes a list of future per-cycle observations.
  typedef struct packed {
    logic x;
    logic v;
    logic b;
    logic d;
  } obs_t;

  localparam obs_t IDLE_OBS = '{x: 1'b0, v: 1'b0, b: 1'b0, d: 1'b0};
  int   gap_of [2] = '{2, 0};
  obs_t q [2][$];
  obs_t cur [2];
  bit   started = 1'b0;

  function automatic int model_len(input logic [3:0] l);
    return (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      obs_t nxt;
      if (!rst_n || abort) begin
        q[d].delete();
        nxt = IDLE_OBS;
      end else begin
        if (!cur[d].b && load_valid) begin
          int len;
          len = model_len(load_len);
          for (int i = len - 1; i >= 0; i--)
            q[d].push_back('{x: load_data[i], v: 1'b1, b: 1'b1, d: (i == 0)});
          for (int g = 0; g < gap_of[d]; g++)
            q[d].push_back('{x: 1'b0, v: 1'b0, b: 1'b1, d: 1'b0});
        end
        nxt = (q[d].size() > 0) ? q[d].pop_front() : IDLE_OBS;
      end
      cur[d] <= nxt;
    end
    if (!rst_n) started <= 1'b1;
  end

  task automatic cmp_dut(input int d, input logic x, input logic v, input logic b,
                         input logic dn, input logic r);
    check($sformatf("x_out[gap%0d]", gap_of[d]), 32'(x), 32'(cur[d].x));
    check($sformatf("x_valid[gap%0d]", gap_of[d]), 32'(v), 32'(cur[d].v));
    check($sformatf("busy[gap%0d]", gap_of[d]), 32'(b), 32'(cur[d].b));
    check($sformatf("done[gap%0d]", gap_of[d]), 32'(dn), 32'(cur[d].d));
    check($sformatf("load_ready[gap%0d]", gap_of[d]), 32'(r), 32'(!cur[d].b && rst_n && !abort));
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_dut(0, x0, v0, b0, d0, ready0);
      cmp_dut(1, x1, v1, b1, d1, ready1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    load_valid = 1'b0;
    abort      = 1'b0;
    rst_n      = 1'b1;
    #0;
    while (!(ready0 && ready1) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("idle_timeout", {30'd0, ready0, ready1}, 32'h3);
  endtask

  // Offer a frame in the current cycle (cycle 0); returns in cycle 1.
  task automatic offer(input logic [7:0] data, input logic [3:0] len);
    load_valid = 1'b1;
    load_data  = data;
    load_len   = len;
    tick();
    load_valid = 1'b0;
    load_data  = 8'($urandom);
  endtask

  initial begin
    bit [6:0] xv, vv, dv;
    bit [7:0] bits;

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_len   = 4'd0;
    abort      = 1'b0;
    tick(); tick();
    check("reset_x_out", 32'(x0), 32'h0);
    check("reset_x_valid", 32'(v0), 32'h0);
    check("reset_busy", 32'(b0), 32'h0);
    check("reset_done", 32'(d0), 32'h0);
    check("reset_ready", 32'(ready0), 32'h0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", 32'(ready0), 32'h1);

    // 4-bit frame 1011 with a 2-cycle gap.
    wait_idle();
    offer(8'h0B, 4'd4);
    xv = 7'b1011000; vv = 7'b1111000; dv = 7'b0001000;
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("f0B_x c%0d", i), 32'(x0), 32'(xv[7-i]));
      check($sformatf("f0B_v c%0d", i), 32'(v0), 32'(vv[7-i]));
      check($sformatf("f0B_done c%0d", i), 32'(d0), 32'(dv[7-i]));
      check($sformatf("f0B_ready c%0d", i), 32'(ready0), 32'(i == 7));
      if (i < 7) tick();
    end

    // load_len=0 means full width.
    wait_idle();
    offer(8'hA5, 4'd0);
    bits = 8'b10100101;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("fA5_x c%0d", i), 32'(x0), 32'(bits[8-i]));
      check($sformatf("fA5_done c%0d", i), 32'(d0), 32'(i == 8));
      tick();
    end

    // Gap-free instance, back-to-back frames with load_valid held.
    wait_idle();
    load_valid = 1'b1; load_data = 8'b110; load_len = 4'd3;
    tick();
    load_data = 8'b011;
    xv = 7'b1100011; vv = 7'b1110111;
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("b2b_x c%0d", i), 32'(x1), 32'(xv[7-i]));
      check($sformatf("b2b_v c%0d", i), 32'(v1), 32'(vv[7-i]));
      if (i == 4) check("b2b_ready c4", 32'(ready1), 32'h1);
      tick();
    end
    load_valid = 1'b0;

    // Abort in cycle 2 of an 8-bit frame.
    wait_idle();
    offer(8'hFF, 4'd8);
    for (int i = 1; i <= 5; i++) begin
      abort = (i == 2);
      #0;
      check($sformatf("abort_v c%0d", i), 32'(v0), 32'(i <= 2));
      check($sformatf("abort_done c%0d", i), 32'(d0), 32'h0);
      if (i == 3) check("abort_ready c3", 32'(ready0), 32'h1);
      tick();
    end
    abort = 1'b0;

    // load_valid pulse during SHIFT is ignored.
    wait_idle();
    offer(8'hC3, 4'd8);
    bits = 8'hC3;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin load_valid = 1'b1; load_data = 8'hFF; load_len = 4'd2; end
      else load_valid = 1'b0;
      #0;
      check($sformatf("pulse_x c%0d", i), 32'(x0), 32'(bits[8-i]));
      check($sformatf("pulse_done c%0d", i), 32'(d0), 32'(i == 8));
      tick();
    end
    load_valid = 1'b0;

    // Reset in cycle 3 of a frame, then a fresh frame.
    wait_idle();
    offer(8'h96, 4'd8);
    tick(); tick();
    rst_n = 1'b0;
    #0;
    check("rst_mid_ready c3", 32'(ready0), 32'h0);
    tick();
    check("rst_mid_x c4", 32'(x0), 32'h0);
    check("rst_mid_v c4", 32'(v0), 32'h0);
    check("rst_mid_busy c4", 32'(b0), 32'h0);
    check("rst_mid_done c4", 32'(d0), 32'h0);
    check("rst_mid_ready c4", 32'(ready0), 32'h0);
    tick();
    rst_n = 1'b1;
    #0;
    check("rst_release_ready", 32'(ready0), 32'h1);
    offer(8'h5A, 4'd8);
    bits = 8'h5A;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("post_rst_x c%0d", i), 32'(x0), 32'(bits[8-i]));
      check($sformatf("post_rst_done c%0d", i), 32'(d0), 32'(i == 8));
      tick();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      abort      = ($urandom_range(0, 24) == 0);
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = 8'($urandom);
      load_len   = 4'($urandom_range(0, 15));
      tick();
    end
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
